// File: rtl/vrf_agu_grp.sv
// VRF address generator: walks the lines covered by one vector op and streams
// address, line index, byte enables and start/end flags over valid/ready.
module vrf_agu_grp #(
  parameter int unsigned DATA_BYTES    = 8,
  parameter int unsigned LINES_PER_REG = 32,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned VL_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [VL_WIDTH-1:0]   vl_in,
  input  logic [4:0]            vreg_in,
  input  logic [1:0]            vsew,
  input  logic                  masked,
  input  logic [1:0]            mode,
  input  logic [DATA_BYTES-1:0] mask_in,
  input  logic                  resp_ready,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [7:0]            line_idx,
  output logic [DATA_BYTES-1:0] b_en,
  output logic                  start_v,
  output logic                  end_v,
  output logic                  done
);

  localparam int unsigned LogDb = $clog2(DATA_BYTES);
  localparam logic [1:0] ModeNormal = 2'd0;
  localparam logic [1:0] ModeRepeat = 2'd1;
  localparam logic [1:0] ModeScalar = 2'd2;

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                state_q, state_d;
  logic [VL_WIDTH-1:0]   vl_q, vl_d;
  logic [4:0]            vreg_q, vreg_d;
  logic [1:0]            vsew_q, vsew_d;
  logic                  masked_q, masked_d;
  logic [1:0]            mode_q, mode_d;
  logic [31:0]           k_q, k_d;
  logic                  rep_q, rep_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            idx_q, idx_d;
  logic [DATA_BYTES-1:0] ben_q, ben_d;
  logic                  start_q, start_d;
  logic                  end_q, end_d;
  logic                  done_q, done_d;

  logic                  accept;
  logic [VL_WIDTH-1:0]   c_vl;
  logic [4:0]            c_vreg;
  logic [1:0]            c_vsew;
  logic                  c_masked;
  logic [1:0]            c_mode;
  logic [31:0]           shift, epl, lines, base, k_nxt, act, nbytes;
  logic                  last_cur, last_nxt;
  logic [DATA_BYTES-1:0] ben_line;

  // Line geometry comes from the incoming request on the accept edge and from
  // the latched op otherwise, so line 0 and line k+1 share one datapath.
  always_comb begin
    accept   = req_valid && (state_q == StIdle);
    c_vl     = accept ? vl_in : vl_q;
    c_vreg   = accept ? vreg_in : vreg_q;
    c_vsew   = accept ? vsew : vsew_q;
    c_masked = accept ? masked : masked_q;
    c_mode   = accept ? ((mode == 2'd3) ? ModeNormal : mode) : mode_q;

    // Illegal vsew clamps to one element per line so the op still terminates.
    shift    = (32'(c_vsew) > LogDb) ? 32'd0 : LogDb - 32'(c_vsew);
    epl      = 32'd1 << shift;
    lines    = (32'(c_vl) + epl - 32'd1) >> shift;
    base     = 32'(c_vreg) * LINES_PER_REG;
    k_nxt    = accept ? 32'd0 : k_q + 32'd1;
    last_cur = (k_q == lines - 32'd1);
    last_nxt = (k_nxt == lines - 32'd1);
    act      = 32'(c_vl) - ((lines - 32'd1) << shift);
    nbytes   = act << c_vsew;

    if (!last_nxt || nbytes >= DATA_BYTES) begin
      ben_line = {DATA_BYTES{1'b1}};
    end else begin
      ben_line = DATA_BYTES'((64'd1 << nbytes) - 64'd1);
    end
    if (c_masked) begin
      ben_line = ben_line & mask_in;
    end
  end

  always_comb begin
    state_d  = state_q;
    vl_d     = vl_q;
    vreg_d   = vreg_q;
    vsew_d   = vsew_q;
    masked_d = masked_q;
    mode_d   = mode_q;
    k_d      = k_q;
    rep_d    = rep_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    ben_d    = ben_q;
    start_d  = start_q;
    end_d    = end_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          vl_d     = c_vl;
          vreg_d   = c_vreg;
          vsew_d   = c_vsew;
          masked_d = c_masked;
          mode_d   = c_mode;
          if (vl_in == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StIssue;
            k_d     = k_nxt;
            rep_d   = 1'b0;
            addr_d  = ADDR_WIDTH'((c_mode == ModeScalar) ? base : base + k_nxt);
            idx_d   = k_nxt[7:0];
            ben_d   = ben_line;
            start_d = 1'b1;
            end_d   = last_nxt && (c_mode != ModeRepeat);
          end
        end
      end
      StIssue: begin
        if (resp_ready) begin
          if (mode_q == ModeRepeat && !rep_q) begin
            // Second copy of the same line: mask_in is deliberately not resampled.
            rep_d   = 1'b1;
            start_d = 1'b0;
            end_d   = last_cur;
          end else if (last_cur) begin
            state_d = StIdle;
            done_d  = 1'b1;
            start_d = 1'b0;
            end_d   = 1'b0;
          end else begin
            k_d     = k_nxt;
            rep_d   = 1'b0;
            addr_d  = ADDR_WIDTH'((mode_q == ModeScalar) ? base : base + k_nxt);
            idx_d   = k_nxt[7:0];
            ben_d   = ben_line;
            start_d = 1'b0;
            end_d   = last_nxt && (mode_q != ModeRepeat);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      vl_q     <= '0;
      vreg_q   <= '0;
      vsew_q   <= '0;
      masked_q <= 1'b0;
      mode_q   <= '0;
      k_q      <= '0;
      rep_q    <= 1'b0;
      addr_q   <= '0;
      idx_q    <= '0;
      ben_q    <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vl_q     <= vl_d;
      vreg_q   <= vreg_d;
      vsew_q   <= vsew_d;
      masked_q <= masked_d;
      mode_q   <= mode_d;
      k_q      <= k_d;
      rep_q    <= rep_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      ben_q    <= ben_d;
      start_q  <= start_d;
      end_q    <= end_d;
      done_q   <= done_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StIssue);
  assign addr_out   = addr_q;
  assign line_idx   = idx_q;
  assign b_en       = ben_q;
  assign start_v    = start_q;
  assign end_v      = end_q;
  assign done       = done_q;

endmodule

// File: doc/vrf_agu_grp.md
# vrf_agu_grp

Parametrised vector-register-file address generator for the vector unit. It accepts one vector-op request and walks every VRF line covered by `vl` elements, starting at the base of register `vreg_in` and running across consecutive registers for LMUL grouping. For each line it emits an address, a byte enable with tail and mask applied, and start/end flags over a valid/ready stream. It adds configurable line width, element width, a repeat mode, a scalar/reduction mode and a completion pulse.

## Interface
Parameters:
- `DATA_BYTES`, 8: bytes per VRF line and width of `b_en`; power of two, 1..64.
- `LINES_PER_REG`, 32: VRF lines per architectural register.
- `ADDR_WIDTH`, 10: width of `addr_out`.
- `VL_WIDTH`, 16: width of `vl_in`.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request offered.
- `req_ready` out 1: block idle and able to accept a request.
- `vl_in` in VL_WIDTH: element count.
- `vreg_in` in 5: base register.
- `vsew` in 2: element width is 1<<vsew bytes; must not exceed DATA_BYTES.
- `masked` in 1: apply `mask_in` to every beat.
- `mode` in 2: 0 normal, 1 repeat, 2 scalar; 3 is treated as 0.
- `mask_in` in DATA_BYTES: byte-granular mask for the line being loaded.
- `resp_ready` in 1: consumer accepts the current beat.
- `resp_valid` out 1: beat valid.
- `addr_out` out ADDR_WIDTH: VRF line address.
- `line_idx` out 8: line index within the op.
- `b_en` out DATA_BYTES: byte enables.
- `start_v` out 1: first beat of the op.
- `end_v` out 1: last beat of the op.
- `done` out 1: one-cycle pulse when the op completes.

## Operation
- States: IDLE (`req_ready`=1, `resp_valid`=0) and ISSUE (`req_ready`=0, `resp_valid`=1).
- Accept: on `req_valid & req_ready`, latch `vl_in`, `vreg_in`, `vsew`, `masked` and `mode`.
  - `epl = DATA_BYTES >> vsew`.
  - `lines = ceil(vl/epl)`.
  - `base = vreg_in*LINES_PER_REG`, computed at full width.
- Line k:
  - `addr_out = (base + k)` truncated to ADDR_WIDTH, so it wraps modulo 2^ADDR_WIDTH. In scalar mode `addr_out = base` for every k.
  - `line_idx` = k, truncated to 8 bits.
- Byte enables:
  - Every line except the last has `b_en` all ones.
  - The last line has `act = vl - (lines-1)*epl` active elements; its `b_en` has the low `act<<vsew` bits set.
  - If `masked`, `b_en &= mask_in`.
  - `mask_in` is sampled only when a new line is loaded into the output registers: line 0 on the accept edge, line k+1 on the handshake edge of line k.
- Beats:
  - Normal and scalar modes produce one beat per line.
  - Repeat mode produces two consecutive beats per line with identical `addr_out`, `b_en` and `line_idx`. `mask_in` is not resampled for the second beat.
- Flags:
  - `start_v` is 1 only on beat 0.
  - `end_v` is 1 only on the final beat (the second copy of the last line in repeat mode).
  - When `lines == 1` in normal mode, both flags are 1 on the same beat.
- Completion: a handshake on the final beat moves to IDLE. On the next cycle `req_ready`=1, `resp_valid`=0 and `done`=1 for one cycle.
- `vl_in == 0`: the request is accepted and no beat is issued. The next cycle has `done`=1 and `req_ready` stays 1.
- `vsew` with `(1<<vsew) > DATA_BYTES` is illegal; behaviour is unspecified, but the FSM must still return to IDLE.

## Timing
- Reset values after a `rst` edge:
  - `req_ready`=1.
  - `resp_valid`, `start_v`, `end_v`, `done` = 0.
  - `addr_out`, `line_idx`, `b_en` = 0.
  - State = IDLE.
- Reset during ISSUE aborts the op; the next cycle shows the reset values above.
- Latency: a request accepted at edge t presents beat 0 in cycle t+1.
- With `resp_ready` held high, one beat is issued per cycle and there are no bubbles between lines.
- Backpressure: while `resp_valid & !resp_ready`, all outputs hold stable and `mask_in` is ignored.
- All outputs are registered; no combinational path from any input to any output.
- Back-to-back ops: the next accept is possible in the `done` cycle, giving a minimum one-cycle gap between ops.

## Test plan
All scenarios use DATA_BYTES=8 and LINES_PER_REG=32.
- vl=20, vsew=1, vreg=3, mode 0, `resp_ready`=1 -> 5 beats, addr 96..100, all `b_en`=0xFF, `start_v` on 96, `end_v` on 100, `done` the cycle after.
- vl=11, vsew=2, vreg=5, mode 0 -> 6 beats, addr 160..165, last `b_en`=0x0F; `resp_ready` low for 3 cycles at beat 2 -> addr 162 is held for 3 cycles with no beat lost or duplicated.
- vl=3, vsew=0, masked=1, `mask_in`=0xAA -> single beat, `b_en`=0x02, `start_v`=`end_v`=1.
- Repeat: vl=2, vsew=3, vreg=1, mode 1 -> beats 32, 32, 33, 33 with `b_en`=0xFF; `start_v` on beat 1 only, `end_v` on beat 4 only.
- Scalar: vl=24, vsew=0, vreg=2, mode 2 -> 3 beats, all at addr 64, `line_idx` 0, 1, 2.
- vl=0 -> no `resp_valid`, `done`=1 one cycle after accept. Separately, `rst` asserted at beat 2 of a 5-beat op -> next cycle `resp_valid`=0, `req_ready`=1, `b_en`=0.
